// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts out the low len bits of pattern MSB-first,
// repeated reps+1 times with a one-cycle gap between copies, then pulses done.
// Latency: first bit one cycle after start is accepted; no stalls. start is only
// accepted while ready=1; abort cancels a transfer in SHIFT/GAP.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      load request (accepted only when ready=1)
//   pattern    bits to send (low len bits, MSB of that field first)
//   len        bits per transmission (0 or >WIDTH means WIDTH)
//   reps       extra repetitions (total transmissions = reps+1)
//   abort      cancels an active transfer (SHIFT or GAP)
//   ready      idle and not in reset
//   busy       in SHIFT, GAP or DONE
//   out        registered serial bit
//   out_valid  out carries a pattern bit this cycle
//   done       one-cycle completion pulse
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_pat;     // captured pattern, left-aligned so bit WIDTH-1 is first
  logic [WIDTH-1:0]   r_sh;      // working shift register for the current transmission
  logic [LW-1:0]      r_len;
  logic [3:0]         r_reps;    // repetitions still to send after the current one
  logic [LW-1:0]      r_bitcnt;  // bits already presented in this transmission
  logic               r_out;
  logic               r_out_valid;
  logic               r_done;

  logic [LW-1:0]      w_eff_len;
  logic [LW-1:0]      w_shamt;
  logic [WIDTH-1:0]   w_aligned;

  // Out-of-range lengths collapse to a full-width transfer.
  assign w_eff_len = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;
  assign w_shamt   = FULL_LEN - w_eff_len;
  // Left-align so the MSB of the used field always sits at bit WIDTH-1;
  // the unused high bits of pattern are shifted out and never transmitted.
  assign w_aligned = pattern << w_shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_sh        <= '0;
      r_len       <= '0;
      r_reps      <= '0;
      r_bitcnt    <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          // abort has no meaning here, so start always wins
          if (start) begin
            r_pat       <= w_aligned;
            r_sh        <= w_aligned << 1;
            r_len       <= w_eff_len;
            r_reps      <= reps;
            r_bitcnt    <= LW'(1);
            r_out       <= w_aligned[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (abort) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_bitcnt    <= '0;
            r_state     <= S_IDLE;
          end else if (r_bitcnt == r_len) begin
            // the bit on out now is the last of this transmission
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_bitcnt    <= '0;
            if (r_reps != 4'd0) begin
              r_state <= S_GAP;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_out    <= r_sh[WIDTH-1];
            r_sh     <= r_sh << 1;
            r_bitcnt <= r_bitcnt + LW'(1);
          end
        end

        S_GAP: begin
          if (abort) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            // restart from the captured pattern; first bit goes out immediately
            r_reps      <= r_reps - 4'd1;
            r_sh        <= r_pat << 1;
            r_out       <= r_pat[WIDTH-1];
            r_out_valid <= 1'b1;
            r_bitcnt    <= LW'(1);
            r_state     <= S_SHIFT;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed transfers, expected bit/done events queued
// with their cycle numbers; a negedge monitor pops and compares each output event.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       out;
  logic       out_valid;
  logic       done;

  seq_pattern_tx #(.WIDTH(8), .LW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic is_done;
    logic b;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid || done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: out_valid=%0b done=%0b out=%0b at cyc %0d, expected no output",
                 out_valid, done, out, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind_done", int'(done), int'(e.is_done));
        if (!e.is_done) chk("bit_value", int'(out), int'(e.b));
        chk("event_cycle", cyc, e.cyc);
      end
    end
    if (!out_valid) chk("out_zero_when_invalid", int'(out), 0);
  end

  // Issue a start at the next negedge; push the first nexp expected events
  // (nexp<0 means the whole transfer). Returns t, the cycle before acceptance.
  task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                    input int nexp, output int t);
    exp_t lst[$];
    exp_t e;
    int eff;
    int c;
    @(negedge clk);
    chk("ready_before_start", int'(ready), 1);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    t       = cyc;
    eff = (l == 0 || l > 8) ? 8 : int'(l);
    c   = t + 1;
    for (int rp = 0; rp <= int'(r); rp++) begin
      for (int i = eff - 1; i >= 0; i--) begin
        e.is_done = 1'b0; e.b = p[i]; e.cyc = c;
        lst.push_back(e);
        c++;
      end
      if (rp < int'(r)) c++;
    end
    e.is_done = 1'b1; e.b = 1'b0; e.cyc = c;
    lst.push_back(e);
    for (int k = 0; k < lst.size(); k++)
      if (nexp < 0 || k < nexp) q.push_back(lst[k]);
    @(negedge clk);
    start = 1'b0;
    // scramble inputs: the captured transfer must not notice
    pattern = 8'($urandom);
    len     = 4'($urandom);
    reps    = 4'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_within_budget", int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; abort = 1'b0;

    // reset: two cycles of rst, outputs quiet, ready low
    repeat (2) begin
      @(negedge clk);
      chk("rst_out", int'(out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(ready), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(ready), 1);
    chk("busy_after_release", int'(busy), 0);

    // 3-bit transfer of 101, with an ignored start mid-transfer
    go(8'h05, 4'd3, 4'd0, -1, t);          // now at T+1
    chk("busy_in_shift", int'(busy), 1);
    @(negedge clk);                         // T+2
    pattern = 8'hFF; len = 4'd8; reps = 4'd3; start = 1'b1;
    chk("ready_low_while_busy", int'(ready), 0);
    @(negedge clk);                         // T+3
    start = 1'b0;
    @(negedge clk);                         // T+4: done
    chk("ready_low_in_done", int'(ready), 0);
    @(negedge clk);                         // T+5
    chk("ready_at_T5", int'(ready), 1);
    chk("busy_at_T5", int'(busy), 0);

    // full width via len=0, one repetition with a gap
    go(8'hA5, 4'd0, 4'd1, -1, t);
    wait_idle();

    // abort during the first gap: only the first 4 bits, no done
    go(8'h3B, 4'd4, 4'd2, 4, t);
    while (cyc < t + 5) @(negedge clk);
    chk("gap_busy", int'(busy), 1);
    chk("gap_out_valid", int'(out_valid), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ready_after_abort", int'(ready), 1);
    chk("busy_after_abort", int'(busy), 0);
    repeat (3) @(negedge clk);
    go(8'h02, 4'd2, 4'd0, -1, t);
    wait_idle();

    // reset on the third shift cycle of an 8-bit transfer, start held too
    go(8'hC3, 4'd8, 4'd0, 3, t);
    while (cyc < t + 3) @(negedge clk);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    chk("ready_low_in_rst", int'(ready), 0);
    @(negedge clk);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", int'(ready), 1);
    repeat (3) @(negedge clk);

    // len=1, three transmissions of a single bit
    go(8'h01, 4'd1, 4'd2, -1, t);
    wait_idle();

    // len beyond WIDTH means full width; abort together with start loses
    abort = 1'b1;
    go(8'h81, 4'd9, 4'd0, -1, t);
    abort = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
